seg_msg_sched: RTL

//  Arbitrates the shared 4-digit glyph bus num[19:0] (4 x 5-bit glyph codes) of the 7-seg display driver.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/tick_gen.sv | 27 ++
 rtl/seg_msg_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and encodings for the 7-segment message scheduler.
package seg_pkg;

   localparam logic [4:0]  GLYPH_BLANK = 5'd31;
   localparam logic [4:0]  GLYPH_DASH  = 5'd26;
   localparam logic [19:0] BLANK_FRAME = {4{GLYPH_BLANK}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW1 = 2'd1,
      ST_SHOW2 = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_BG = 2'd0,
      OWN_M1 = 2'd1,
      OWN_M2 = 2'd2
   } owner_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running tick prescaler with synchronous clear; tick marks the wrap cycle.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV + 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   // prescaler: 0..TICK_DIV-1, restarted by clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/seg_msg_sched.sv
// Arbitrates the shared 4-digit glyph bus between a background frame and two messages.
module seg_msg_sched
   import seg_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned HOLD_TK  = 1500,
   parameter int unsigned BLINK_TK = 250,
   parameter int unsigned GAP_TK   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] bg_num,
   input  logic        m1_req,
   input  logic [19:0] m1_num,
   input  logic        m1_blink,
   output logic        m1_ack,
   output logic        m1_done,
   input  logic        m2_req,
   input  logic [19:0] m2_num,
   input  logic        m2_blink,
   output logic        m2_ack,
   output logic        m2_done,
   output logic [19:0] num,
   output logic [1:0]  owner,
   output logic        busy
);

   localparam int unsigned HW = $clog2(HOLD_TK + 1);
   localparam int unsigned GW = $clog2(GAP_TK + 1);
   localparam int unsigned BW = $clog2(BLINK_TK + 1);

   state_t        state, state_nx;
   logic          tick, grant1, grant2, grant;
   logic          in_show, hold_end, gap_end, blink_flip;
   logic [HW-1:0] hold_cnt;
   logic [GW-1:0] gap_cnt;
   logic [BW-1:0] blink_cnt;
   logic          phase, phase_nx;
   logic [19:0]   frame, frame_nx;
   logic          blink_en, blink_en_nx;
   logic [19:0]   num_d;
   owner_t        owner_d;
   logic          busy_d;

   assign in_show    = (state == ST_SHOW1) || (state == ST_SHOW2);
   assign grant1     = (state == ST_IDLE) && m1_req;
   assign grant2     = (state == ST_IDLE) && !m1_req && m2_req;
   assign grant      = grant1 || grant2;
   assign hold_end   = tick && (hold_cnt == HW'(HOLD_TK - 1));
   assign gap_end    = tick && (gap_cnt == GW'(GAP_TK - 1));
   assign blink_flip = tick && (blink_cnt == BW'(BLINK_TK - 1));

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (grant),
      .tick (tick)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // next-state: fixed priority m1 over m2, no preemption once showing
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (m1_req)
               state_nx = ST_SHOW1;
            else if (m2_req)
               state_nx = ST_SHOW2;
         end
         ST_SHOW1, ST_SHOW2: if (hold_end) state_nx = ST_GAP;
         ST_GAP:             if (gap_end)  state_nx = ST_IDLE;
         default:            state_nx = ST_IDLE;
      endcase
   end

   // outputs: decoded from the next state so the registered bus lands in step with the state
   always_comb begin
      frame_nx    = frame;
      blink_en_nx = blink_en;
      phase_nx    = phase;
      if (grant1) begin
         frame_nx    = m1_num;
         blink_en_nx = m1_blink;
      end else if (grant2) begin
         frame_nx    = m2_num;
         blink_en_nx = m2_blink;
      end
      if (grant)
         phase_nx = 1'b1;
      else if (in_show && blink_flip)
         phase_nx = ~phase;

      num_d   = bg_num;
      owner_d = OWN_BG;
      case (state_nx)
         ST_SHOW1: begin
            owner_d = OWN_M1;
            num_d   = (blink_en_nx && !phase_nx) ? BLANK_FRAME : frame_nx;
         end
         ST_SHOW2: begin
            owner_d = OWN_M2;
            num_d   = (blink_en_nx && !phase_nx) ? BLANK_FRAME : frame_nx;
         end
         default: ;
      endcase
      busy_d  = (state_nx != ST_IDLE);
      m1_done = (state == ST_SHOW1) && hold_end;
      m2_done = (state == ST_SHOW2) && hold_end;
   end

   // hold/gap/blink counters and the latched message
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt  <= '0;
         gap_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b1;
         frame     <= BLANK_FRAME;
         blink_en  <= 1'b0;
      end else begin
         frame    <= frame_nx;
         blink_en <= blink_en_nx;
         phase    <= phase_nx;
         if (grant) begin
            hold_cnt  <= '0;
            blink_cnt <= '0;
         end else if (in_show && tick) begin
            hold_cnt  <= hold_end   ? '0 : hold_cnt + 1'b1;
            blink_cnt <= blink_flip ? '0 : blink_cnt + 1'b1;
         end
         if (state != ST_GAP)
            gap_cnt <= '0;
         else if (tick)
            gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // registered display bus, owner/busy and grant acknowledges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num    <= BLANK_FRAME;
         owner  <= OWN_BG;
         busy   <= 1'b0;
         m1_ack <= 1'b0;
         m2_ack <= 1'b0;
      end else begin
         num    <= num_d;
         owner  <= owner_d;
         busy   <= busy_d;
         m1_ack <= grant1;
         m2_ack <= grant2;
      end
   end

endmodule
